// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder sequencer.
//   SLICE   : bits added per cycle (width of the fulladder4 slice)
//   ST_*    : FSM state encoding (IDLE -> RUN -> DONE -> IDLE)
package nibble_serial_adder_ctrl_pkg;

  localparam int unsigned SLICE = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/fulladder4.sv
// 4-bit ripple-carry adder slice.
//   a, b : 4-bit addends
//   cin  : carry in
//   s    : 4-bit sum
//   cout : carry out
module fulladder4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] total;

  assign total     = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
  assign s         = total[3:0];
  assign cout      = total[4];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Sequencer performing a WIDTH-bit add through one shared SLICE-bit ripple slice,
// one slice per clock, LSB slice first. Valid/ready on both sides; the result is
// held until accepted.
//   clk, rst_n                  : clock, asynchronous active-low reset
//   in_valid / in_ready         : operand handshake (in_ready only in IDLE)
//   in_a, in_b, in_cin          : operands and carry-in to slice 0
//   out_valid / out_ready       : result handshake (out_valid only in DONE)
//   out_sum, out_cout, out_ovf  : A+B+cin mod 2^WIDTH, MSB carry, signed overflow
// WIDTH must be a multiple of SLICE.
module nibble_serial_adder_ctrl
  import nibble_serial_adder_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int unsigned NSLICES  = WIDTH / SLICE;
  localparam int unsigned CW       = (NSLICES > 1) ? $clog2(NSLICES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NSLICES - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;

  logic [SLICE-1:0] slice_s;
  logic             slice_cout;

  fulladder4 u_slice (
    .a    (a_sh_q[SLICE-1:0]),
    .b    (b_sh_q[SLICE-1:0]),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_cout)
  );

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_sh_d  = in_a;
          b_sh_d  = in_b;
          carry_d = in_cin;
          cnt_d   = '0;
          sa_d    = in_a[WIDTH-1];
          sb_d    = in_b[WIDTH-1];
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_sh_d   = a_sh_q >> SLICE;
        b_sh_d   = b_sh_q >> SLICE;
        // Slice results enter at the top so the LSB slice ends up at bit 0.
        sum_sh_d = {slice_s, sum_sh_q[WIDTH-1:SLICE]};
        carry_d  = slice_cout;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);

  // Result outputs are masked outside DONE so no partial sum is ever visible.
  assign out_sum  = out_valid ? sum_sh_q : '0;
  assign out_cout = out_valid & carry_q;
  assign out_ovf  = out_valid & (sa_q == sb_q) & (sum_sh_q[WIDTH-1] != sa_q);

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
module tb_nibble_serial_adder_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_cin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_cout;
  logic        out_ovf;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  nibble_serial_adder_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: plain 33-bit arithmetic plus signed-overflow rule.
  function automatic logic [33:0] ref_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic cin);
    logic [32:0] t;
    logic        ov;
    t  = {1'b0, a} + {1'b0, b} + {32'd0, cin};
    ov = (a[31] == b[31]) && (t[31] != a[31]);
    return {ov, t};
  endfunction

  // Drives one operation and returns what was observed; callers compare.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic cin,
                       input int hold,
                       output logic [31:0] sum, output logic cout, output logic ovf,
                       output int lat, output bit ok, output bit stable, output int acc);
    int w;
    ok = 1'b1; stable = 1'b1; lat = 0; acc = 0; sum = '0; cout = 1'b0; ovf = 1'b0;
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 50) begin @(posedge clk); #1; w++; end
    if (!in_ready) begin ok = 1'b0; in_valid = 1'b0; return; end
    @(posedge clk); #1;
    acc = cyc;
    in_valid = 1'b0;
    // Scramble operand inputs: the block must not read them after capture.
    in_a = $urandom; in_b = $urandom; in_cin = 1'($urandom);
    while (!out_valid && lat < 30) begin @(posedge clk); #1; lat++; end
    if (!out_valid) begin ok = 1'b0; return; end
    sum = out_sum; cout = out_cout; ovf = out_ovf;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom);
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || out_sum !== sum || out_cout !== cout || out_ovf !== ovf ||
          in_ready !== 1'b0)
        stable = 1'b0;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
    #23;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== 32'd0 || out_cout !== 1'b0 ||
        out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset: in_ready=%b out_valid=%b sum=%h cout=%b ovf=%b, want 1 0 0 0 0",
               in_ready, out_valid, out_sum, out_cout, out_ovf);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [31:0] va [4];
    logic [31:0] vb [4];
    logic        vc [4];
    logic [31:0] es [4];
    logic        ec [4];
    logic        eo [4];
    logic [31:0] s;
    logic        c, o;
    int          lat, acc;
    bit          ok, st;
    va[0] = 32'h0000_0001; vb[0] = 32'h0000_0001; vc[0] = 1'b0;
    es[0] = 32'h0000_0002; ec[0] = 1'b0; eo[0] = 1'b0;
    va[1] = 32'hFFFF_FFFF; vb[1] = 32'h0000_0000; vc[1] = 1'b1;
    es[1] = 32'h0000_0000; ec[1] = 1'b1; eo[1] = 1'b0;
    va[2] = 32'h7FFF_FFFF; vb[2] = 32'h0000_0001; vc[2] = 1'b0;
    es[2] = 32'h8000_0000; ec[2] = 1'b0; eo[2] = 1'b1;
    va[3] = 32'h8000_0000; vb[3] = 32'h8000_0000; vc[3] = 1'b0;
    es[3] = 32'h0000_0000; ec[3] = 1'b1; eo[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_op(va[i], vb[i], vc[i], 0, s, c, o, lat, ok, st, acc);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL directed%0d_timeout: handshake did not complete, want completion", i);
        continue;
      end
      checks++;
      if (s !== es[i] || c !== ec[i] || o !== eo[i]) begin
        errors++;
        $display("FAIL directed%0d_result: sum=%h cout=%b ovf=%b, want %h %b %b",
                 i, s, c, o, es[i], ec[i], eo[i]);
      end
      checks++;
      if (lat != 8) begin
        errors++;
        $display("FAIL directed%0d_latency: got %0d cycles, want 8", i, lat);
      end
    end
  endtask

  task automatic test_backpressure();
    int          w;
    logic [31:0] held;
    in_a = 32'h1234_5678; in_b = 32'h1111_1111; in_cin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 30) begin @(posedge clk); #1; w++; end
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL bp_timeout: out_valid never rose, want 1");
      return;
    end
    held = out_sum;
    checks++;
    if (held !== 32'h2345_678A) begin
      errors++;
      $display("FAIL bp_result: sum=%h, want 2345678a", held);
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_a = $urandom; in_b = $urandom; in_cin = 1'($urandom);
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_sum !== held || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: out_valid=%b sum=%h in_ready=%b, want 1 %h 0",
                 i, out_valid, out_sum, in_ready, held);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
    // Had an operand been captured during DONE, the block would not be idle now.
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_no_capture: in_ready=%b, want 1", in_ready);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] s;
    logic        c, o;
    int          lat, acc;
    bit          ok, st;
    in_a = 32'hFFFF_FFFF; in_b = 32'hFFFF_FFFF; in_cin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== 32'd0 || out_cout !== 1'b0 ||
        out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset: in_ready=%b out_valid=%b sum=%h cout=%b ovf=%b, want 1 0 0 0 0",
               in_ready, out_valid, out_sum, out_cout, out_ovf);
    end
    #4;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL midrun_discard%0d: out_valid=%b in_ready=%b, want 0 1",
                 i, out_valid, in_ready);
      end
    end
    do_op(32'd5, 32'd7, 1'b0, 0, s, c, o, lat, ok, st, acc);
    checks++;
    if (!ok || s !== 32'd12 || c !== 1'b0 || o !== 1'b0) begin
      errors++;
      $display("FAIL midrun_after: ok=%b sum=%h cout=%b ovf=%b, want 1 0000000c 0 0",
               ok, s, c, o);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, s;
    logic        cin, c, o;
    logic [33:0] r;
    int          lat, acc, prev, hold, gap, bad;
    bit          ok, st;
    prev = -1;
    bad  = 0;
    for (int n = 0; n < 1000; n++) begin
      a = $urandom; b = $urandom; cin = 1'($urandom);
      case ($urandom_range(0, 3))
        0: a = 32'hFFFF_FFFF;
        1: b = a ^ 32'h8000_0000;
        default: ;
      endcase
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      gap  = $urandom_range(0, 2);
      repeat (gap) begin @(posedge clk); #1; end
      do_op(a, b, cin, hold, s, c, o, lat, ok, st, acc);
      r = ref_add(a, b, cin);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL rand%0d_timeout: handshake did not complete, want completion", n);
        continue;
      end
      checks++;
      if (s !== r[31:0] || c !== r[32] || o !== r[33]) begin
        errors++; bad++;
        if (bad < 10)
          $display("FAIL rand%0d_result: a=%h b=%h cin=%b got %h %b %b, want %h %b %b",
                   n, a, b, cin, s, c, o, r[31:0], r[32], r[33]);
      end
      checks++;
      if (lat != 8 || !st) begin
        errors++; bad++;
        if (bad < 10)
          $display("FAIL rand%0d_timing: latency=%0d stable=%b, want 8 1", n, lat, st);
      end
      if (prev >= 0) begin
        checks++;
        if (acc - prev < 10) begin
          errors++; bad++;
          if (bad < 10)
            $display("FAIL rand%0d_interval: got %0d cycles, want >= 10", n, acc - prev);
        end
      end
      prev = acc;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
